// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : phase encodings shared by the sequencer, VIO wrapper, bench
// Revision: 1.0
// ============================================================================
package cpu_ctrl_pkg;
   localparam int PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE   = 3'd0,
      PH_FETCH  = 3'd1,
      PH_DECODE = 3'd2,
      PH_EXEC   = 3'd3,
      PH_MEM    = 3'd4,
      PH_WB     = 3'd5
   } phase_e;
endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with asynchronous active-low clear
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// exec_sequencer : multi-phase instruction sequencer issuing one-cycle write
//                  strobes, with single-step, free-run, halt and PC breakpoint
// Revision: 1.0
// ============================================================================
module exec_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int W        = 32,
   parameter int CNT_W    = 32,
   parameter int MEM_WAIT = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               step,
   input  logic               run,
   input  logic               halt_req,
   input  logic               bp_en,
   input  logic [W-1:0]       bp_addr,
   input  logic [W-1:0]       pc,
   input  logic               is_load,
   input  logic               is_store,
   output logic               pc_we,
   output logic               rf_we_gate,
   output logic               dm_we_gate,
   output logic [PHASE_W-1:0] phase,
   output logic               busy,
   output logic               bp_hit,
   output logic [CNT_W-1:0]   retired_cnt
);
   localparam logic [3:0] c_MEM_WAIT = 4'(MEM_WAIT);

   phase_e     r_state, w_state_nxt;
   logic       r_first, w_first_nxt;
   logic       r_single, w_single_nxt;
   logic       r_bp_hit, w_bp_hit_nxt;
   logic [3:0] r_wait, w_wait_nxt;
   logic       w_retire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= PH_IDLE;
         r_first  <= 1'b0;
         r_single <= 1'b0;
         r_bp_hit <= 1'b0;
         r_wait   <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_first  <= w_first_nxt;
         r_single <= w_single_nxt;
         r_bp_hit <= w_bp_hit_nxt;
         r_wait   <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_first_nxt  = r_first;
      w_single_nxt = r_single;
      w_bp_hit_nxt = r_bp_hit;
      w_wait_nxt   = r_wait;
      case (r_state)
         PH_IDLE: begin
            if (step || run) begin
               w_state_nxt  = PH_FETCH;
               w_single_nxt = step;
               w_first_nxt  = 1'b1;
               w_bp_hit_nxt = 1'b0;
            end
         end
         PH_FETCH: begin
            // The first fetch after a start may sit on the breakpoint, so we can step off it
            w_first_nxt = 1'b0;
            if (!r_first && bp_en && (pc == bp_addr)) begin
               w_state_nxt  = PH_IDLE;
               w_bp_hit_nxt = 1'b1;
            end else begin
               w_state_nxt = PH_DECODE;
            end
         end
         PH_DECODE: w_state_nxt = PH_EXEC;
         PH_EXEC: begin
            if (is_load || is_store) begin
               w_state_nxt = PH_MEM;
               w_wait_nxt  = c_MEM_WAIT;
            end else begin
               w_state_nxt = PH_WB;
            end
         end
         PH_MEM: begin
            if (r_wait == 4'd0) begin
               w_state_nxt = PH_WB;
            end else begin
               w_wait_nxt = r_wait - 4'd1;
            end
         end
         PH_WB: begin
            if (r_single || halt_req || !run) begin
               w_state_nxt = PH_IDLE;
            end else begin
               w_state_nxt = PH_FETCH;
            end
         end
         default: w_state_nxt = PH_IDLE;
      endcase
   end

   assign w_retire   = (r_state == PH_WB);
   assign pc_we      = w_retire;
   assign rf_we_gate = w_retire;
   assign dm_we_gate = (r_state == PH_MEM) && (r_wait == 4'd0) && is_store;
   assign phase      = r_state;
   assign busy       = (r_state != PH_IDLE);
   assign bp_hit     = r_bp_hit;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_retired (
      .clk   (clk),
      .reset (reset),
      .inc   (w_retire),
      .count (retired_cnt)
   );
endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// tb_exec_sequencer : directed self-checking bench for exec_sequencer
// Revision: 1.0
// ============================================================================
module tb_exec_sequencer;
   logic        clk = 1'b0;
   logic        reset, step, run, halt_req, bp_en, is_load, is_store;
   logic [31:0] bp_addr, pc;
   logic        pc_set;
   logic [31:0] pc_set_val;

   logic        pc_we, rf_we_gate, dm_we_gate, busy, bp_hit;
   logic [2:0]  phase;
   logic [31:0] retired_cnt;

   logic        s_pc_we, s_rf_we, s_dm_we, s_busy, s_bp_hit;
   logic [2:0]  s_phase;
   logic [1:0]  s_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // PC model: loads on request, otherwise advances on each retire strobe
   always @(posedge clk) begin
      if (pc_set) pc <= pc_set_val;
      else if (pc_we) pc <= pc + 32'd1;
   end

   exec_sequencer #(.W(32), .CNT_W(32), .MEM_WAIT(2)) u_dut (
      .clk(clk), .reset(reset), .step(step), .run(run), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .is_load(is_load), .is_store(is_store),
      .pc_we(pc_we), .rf_we_gate(rf_we_gate), .dm_we_gate(dm_we_gate), .phase(phase),
      .busy(busy), .bp_hit(bp_hit), .retired_cnt(retired_cnt)
   );

   exec_sequencer #(.W(32), .CNT_W(2), .MEM_WAIT(2)) u_sat (
      .clk(clk), .reset(reset), .step(step), .run(run), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .is_load(is_load), .is_store(is_store),
      .pc_we(s_pc_we), .rf_we_gate(s_rf_we), .dm_we_gate(s_dm_we), .phase(s_phase),
      .busy(s_busy), .bp_hit(s_bp_hit), .retired_cnt(s_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick();
      n_checks++; if (phase !== 3'd3) $display("FAIL pre_reset_exec: got %0d want 3", phase); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (phase !== 3'd0) $display("FAIL reset_phase: got %0d want 0", phase); else n_pass++;
      n_checks++; if ({pc_we, rf_we_gate, dm_we_gate} !== 3'b000)
         $display("FAIL reset_strobes: got %b want 000", {pc_we, rf_we_gate, dm_we_gate}); else n_pass++;
      n_checks++; if (retired_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", retired_cnt); else n_pass++;
      n_checks++; if ({busy, bp_hit} !== 2'b00) $display("FAIL reset_busy_bp: got %b want 00", {busy, bp_hit}); else n_pass++;
      #1 reset = 1'b1;
      tick();
      n_checks++; if (phase !== 3'd0) $display("FAIL post_reset_idle: got %0d want 0", phase); else n_pass++;
   endtask

   task automatic test_step_alu();
      logic [2:0] exp_ph [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
      int we_cnt = 0;
      step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         step = 1'b0;
         if (pc_we) we_cnt++;
         n_checks++; if (phase !== exp_ph[i]) $display("FAIL alu_phase[%0d]: got %0d want %0d", i, phase, exp_ph[i]); else n_pass++;
      end
      n_checks++; if (we_cnt != 1) $display("FAIL alu_pc_we_cycles: got %0d want 1", we_cnt); else n_pass++;
      n_checks++; if (retired_cnt !== 32'd1) $display("FAIL alu_retired: got %0d want 1", retired_cnt); else n_pass++;
      n_checks++; if (s_cnt !== 2'd1) $display("FAIL alu_retired_narrow: got %0d want 1", s_cnt); else n_pass++;
   endtask

   task automatic test_store_wait();
      logic [2:0] exp_ph [7] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
      logic       exp_dm [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      is_store = 1'b1; run = 1'b1;
      tick();
      run = 1'b0;
      n_checks++; if (phase !== 3'd1) $display("FAIL store_fetch: got %0d want 1", phase); else n_pass++;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_checks++; if (phase !== exp_ph[i]) $display("FAIL store_phase[%0d]: got %0d want %0d", i, phase, exp_ph[i]); else n_pass++;
         n_checks++; if (dm_we_gate !== exp_dm[i]) $display("FAIL store_dm_we[%0d]: got %0d want %0d", i, dm_we_gate, exp_dm[i]); else n_pass++;
      end
      is_store = 1'b0;
      n_checks++; if (retired_cnt !== 32'd2) $display("FAIL store_retired: got %0d want 2", retired_cnt); else n_pass++;
   endtask

   task automatic test_breakpoint();
      logic [31:0] base;
      pc_set_val = 32'd0; pc_set = 1'b1; tick(); pc_set = 1'b0;
      bp_en = 1'b1; bp_addr = 32'd3; run = 1'b1;
      base = retired_cnt;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (phase == 3'd0) break;
      end
      run = 1'b0;
      n_checks++; if (phase !== 3'd0) $display("FAIL bp_stop_phase: got %0d want 0", phase); else n_pass++;
      n_checks++; if (bp_hit !== 1'b1) $display("FAIL bp_hit_set: got %0d want 1", bp_hit); else n_pass++;
      n_checks++; if (pc !== 32'd3) $display("FAIL bp_pc: got %0d want 3", pc); else n_pass++;
      n_checks++; if (retired_cnt - base !== 32'd3) $display("FAIL bp_retired: got %0d want 3", retired_cnt - base); else n_pass++;
      step = 1'b1; tick(); step = 1'b0;
      n_checks++; if (phase !== 3'd1) $display("FAIL bp_step_fetch: got %0d want 1", phase); else n_pass++;
      n_checks++; if (bp_hit !== 1'b0) $display("FAIL bp_hit_clear: got %0d want 0", bp_hit); else n_pass++;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (phase == 3'd0) break;
      end
      n_checks++; if (pc !== 32'd4) $display("FAIL bp_step_pc: got %0d want 4", pc); else n_pass++;
      n_checks++; if (retired_cnt - base !== 32'd4) $display("FAIL bp_step_retired: got %0d want 4", retired_cnt - base); else n_pass++;
      bp_en = 1'b0;
   endtask

   task automatic test_halt();
      run = 1'b1;
      tick(); tick();
      n_checks++; if (phase !== 3'd2) $display("FAIL halt_decode: got %0d want 2", phase); else n_pass++;
      halt_req = 1'b1; step = 1'b1;
      tick(); step = 1'b0;
      tick();
      n_checks++; if ({phase, pc_we, rf_we_gate} !== {3'd5, 2'b11})
         $display("FAIL halt_wb: got phase %0d we %b want phase 5 we 11", phase, {pc_we, rf_we_gate}); else n_pass++;
      tick();
      n_checks++; if (phase !== 3'd0) $display("FAIL halt_idle: got %0d want 0", phase); else n_pass++;
      run = 1'b0; halt_req = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL halt_step_dropped: got busy %0d want 0", busy); else n_pass++;
      n_checks++; if (retired_cnt !== 32'd7) $display("FAIL halt_retired: got %0d want 7", retired_cnt); else n_pass++;
   endtask

   task automatic test_saturate();
      n_checks++; if (s_cnt !== 2'd3) $display("FAIL sat_at_max: got %0d want 3", s_cnt); else n_pass++;
      step = 1'b1; tick(); step = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (phase == 3'd0) break;
      end
      n_checks++; if (retired_cnt !== 32'd8) $display("FAIL sat_wide_cnt: got %0d want 8", retired_cnt); else n_pass++;
      n_checks++; if (s_cnt !== 2'd3) $display("FAIL sat_hold: got %0d want 3", s_cnt); else n_pass++;
   endtask

   initial begin
      reset = 1'b0; step = 1'b0; run = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
      is_load = 1'b0; is_store = 1'b0; bp_addr = 32'd0;
      pc_set = 1'b1; pc_set_val = 32'd0;
      tick(); tick();
      pc_set = 1'b0;
      reset = 1'b1;
      tick();
      test_reset();
      test_step_alu();
      test_store_wait();
      test_breakpoint();
      test_halt();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
